frame_swap_scheduler: RTL and testbench

Sequencing controller for the double-buffered pixel memory between the SPI frame loader and the panel scan driver. Grants the loader the back buffer via `ready`/`loaded`, holds each completed image for a minimum number of scanned frames, and toggles the memory bank select only on a frame boundary so the panel never shows a torn image. Also flags protocol errors and a stale image.

---
 rtl/frame_swap_scheduler.sv | 103 ++++++++++
 tb/tb_frame_swap_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/frame_swap_scheduler.sv
// Double-buffer swap sequencer: grants the loader the back buffer, holds each
// image for a minimum number of frames and flips banks only on frame boundaries.
module frame_swap_scheduler #(
    parameter int CNT_W       = 8,
    parameter int HOLD_FRAMES = 1,
    parameter int STALE_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_complete,
    input  logic             loaded,
    input  logic             freeze,
    output logic             ready,
    output logic             flip,
    output logic             swap_pulse,
    output logic [CNT_W-1:0] frame_count,
    output logic             stale,
    output logic             dropped,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {LOADING = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [CNT_W:0]   HOLD_C  = HOLD_FRAMES[CNT_W:0];
    localparam logic [CNT_W-1:0] STALE_C = STALE_LIMIT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MAX_C   = '1;
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   ONE_W   = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             flip_q, flip_d;
    logic             swap_pulse_q, swap_pulse_d;
    logic             dropped_q, dropped_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             hold_ok, swap_now;

    // One bit wider so frame_count at all-ones cannot wrap the compare.
    assign hold_ok  = ({1'b0, frame_count_q} + ONE_W) >= HOLD_C;
    assign swap_now = frame_complete && hold_ok && !freeze &&
                      (state_q == PENDING || loaded);

    always_comb begin
        state_d       = state_q;
        flip_d        = flip_q;
        swap_pulse_d  = 1'b0;
        dropped_d     = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;

        if (swap_now) begin
            flip_d        = ~flip_q;
            swap_pulse_d  = 1'b1;
            frame_count_d = '0;
            state_d       = LOADING;
        end else if (frame_complete && frame_count_q != MAX_C) begin
            frame_count_d = frame_count_q + ONE_C;
        end

        // A load while PENDING wrote a bank that was never granted, even if
        // the pending image swaps out in this same cycle.
        if (loaded) begin
            if (state_q == PENDING) begin
                dropped_d = 1'b1;
                if (err_count_q != MAX_C) err_count_d = err_count_q + ONE_C;
            end else if (!swap_now) begin
                state_d = PENDING;
            end
        end

        ready_d = (state_d == LOADING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOADING;
            ready_q       <= 1'b1;
            flip_q        <= 1'b0;
            swap_pulse_q  <= 1'b0;
            dropped_q     <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            flip_q        <= flip_d;
            swap_pulse_q  <= swap_pulse_d;
            dropped_q     <= dropped_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign ready       = ready_q;
    assign flip        = flip_q;
    assign swap_pulse  = swap_pulse_q;
    assign dropped     = dropped_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign stale       = (frame_count_q >= STALE_C);

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Bench for frame_swap_scheduler: vector table through a scoreboard queue on
// instance A (HOLD=1, STALE=4), hand sequences for saturation, hold and reset.
module tb_frame_swap_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_fc = 0, a_ld = 0, a_frz = 0;
    logic       a_rdy, a_flp, a_sw, a_stl, a_drp;
    logic [7:0] a_fcnt, a_err;

    logic       b_fc = 0, b_ld = 0, b_frz = 0;
    logic       b_rdy, b_flp, b_sw, b_stl, b_drp;
    logic [7:0] b_fcnt, b_err;

    frame_swap_scheduler #(.CNT_W(8), .HOLD_FRAMES(1), .STALE_LIMIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_complete(a_fc), .loaded(a_ld), .freeze(a_frz),
        .ready(a_rdy), .flip(a_flp), .swap_pulse(a_sw), .frame_count(a_fcnt),
        .stale(a_stl), .dropped(a_drp), .err_count(a_err));

    frame_swap_scheduler #(.CNT_W(8), .HOLD_FRAMES(3), .STALE_LIMIT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_complete(b_fc), .loaded(b_ld), .freeze(b_frz),
        .ready(b_rdy), .flip(b_flp), .swap_pulse(b_sw), .frame_count(b_fcnt),
        .stale(b_stl), .dropped(b_drp), .err_count(b_err));

    typedef struct {
        logic fc, ld, frz;
        logic rdy, flp, sw, drp, stl;
        logic [7:0] fcnt, err;
    } vec_t;

    vec_t tbl[20];
    vec_t sb[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(logic fc, logic ld, logic frz, logic rdy, logic flp,
                                logic sw, logic drp, logic stl, logic [7:0] fcnt, logic [7:0] err);
        vec_t v;
        v.fc = fc; v.ld = ld; v.frz = frz;
        v.rdy = rdy; v.flp = flp; v.sw = sw; v.drp = drp; v.stl = stl;
        v.fcnt = fcnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive A at the falling edge, sample #1 after the next rising edge.
    task automatic cyc(input logic fc, input logic ld, input logic frz);
        @(negedge clk);
        a_fc = fc; a_ld = ld; a_frz = frz;
        @(posedge clk);
        #1;
        a_fc = 0; a_ld = 0; a_frz = 0;
    endtask

    task automatic cycb(input logic fc, input logic ld);
        @(negedge clk);
        b_fc = fc; b_ld = ld;
        @(posedge clk);
        #1;
        b_fc = 0; b_ld = 0;
    endtask

    initial begin
        vec_t e;
        //            fc ld fz  rdy flp sw drp stl fcnt err
        tbl[0]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 0,  1, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0,  0, 0, 0, 1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0,  0, 1, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 1, 0,  1, 0, 1, 1, 0, 0, 2);
        tbl[10] = mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 2);
        tbl[11] = mk(1, 0, 1,  0, 0, 0, 0, 0, 1, 2);
        tbl[12] = mk(1, 0, 1,  0, 0, 0, 0, 0, 2, 2);
        tbl[13] = mk(1, 0, 1,  0, 0, 0, 0, 0, 3, 2);
        tbl[14] = mk(1, 0, 1,  0, 0, 0, 0, 1, 4, 2);
        tbl[15] = mk(1, 0, 1,  0, 0, 0, 0, 1, 5, 2);
        tbl[16] = mk(0, 0, 1,  0, 0, 0, 0, 1, 5, 2);
        tbl[17] = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 2);
        tbl[18] = mk(0, 0, 0,  1, 1, 0, 0, 0, 0, 2);
        tbl[19] = mk(1, 0, 0,  1, 1, 0, 0, 0, 1, 2);

        // Reset state while rst_n is held low across an edge.
        @(posedge clk); #1;
        chk("rst_ready", a_rdy, 1);
        chk("rst_flip", a_flp, 0);
        chk("rst_swap", a_sw, 0);
        chk("rst_drop", a_drp, 0);
        chk("rst_fcnt", a_fcnt, 0);
        chk("rst_err", a_err, 0);
        chk("rst_stale", a_stl, 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_fc = tbl[i].fc; a_ld = tbl[i].ld; a_frz = tbl[i].frz;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            a_fc = 0; a_ld = 0; a_frz = 0;
            if (sb.size() == 0) begin
                chk($sformatf("sb_empty_%0d", i), 0, 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_ready", i), a_rdy, e.rdy);
                chk($sformatf("v%0d_flip", i), a_flp, e.flp);
                chk($sformatf("v%0d_swap", i), a_sw, e.sw);
                chk($sformatf("v%0d_drop", i), a_drp, e.drp);
                chk($sformatf("v%0d_stale", i), a_stl, e.stl);
                chk($sformatf("v%0d_fcnt", i), a_fcnt, e.fcnt);
                chk($sformatf("v%0d_err", i), a_err, e.err);
            end
        end

        // err_count saturation: pending, then 300 rejected loads.
        cyc(0, 1, 0);
        chk("sat_pending_ready", a_rdy, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 0);
        chk("sat_err", a_err, 255);
        chk("sat_drop", a_drp, 1);
        cyc(1, 0, 0);
        chk("sat_swap_flip", a_flp, 0);
        chk("sat_swap_pulse", a_sw, 1);
        chk("sat_swap_ready", a_rdy, 1);
        chk("sat_err_hold", a_err, 255);

        // frame_count saturation with no image pending.
        for (int i = 0; i < 300; i++) cyc(1, 0, 0);
        chk("fsat_fcnt", a_fcnt, 255);
        chk("fsat_stale", a_stl, 1);
        chk("fsat_flip", a_flp, 0);

        // HOLD_FRAMES=3 on instance B.
        cycb(0, 1);
        chk("h3_ready0", b_rdy, 0);
        cycb(1, 0);
        chk("h3_fcnt1", b_fcnt, 1);
        chk("h3_noswap1", b_flp, 0);
        cycb(0, 0);
        cycb(1, 0);
        chk("h3_fcnt2", b_fcnt, 2);
        chk("h3_noswap2", b_sw, 0);
        cycb(1, 0);
        chk("h3_flip", b_flp, 1);
        chk("h3_swap", b_sw, 1);
        chk("h3_ready1", b_rdy, 1);
        chk("h3_fcnt0", b_fcnt, 0);
        cycb(0, 1);

        // Async reset mid-PENDING on both instances.
        cyc(1, 1, 0);
        chk("pre_flip", a_flp, 1);
        cyc(0, 1, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        chk("pre_fcnt", a_fcnt, 2);
        chk("pre_ready", a_rdy, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ready", a_rdy, 1);
        chk("arst_flip", a_flp, 0);
        chk("arst_fcnt", a_fcnt, 0);
        chk("arst_err", a_err, 0);
        chk("arst_b_ready", b_rdy, 1);
        chk("arst_b_flip", b_flp, 0);
        @(negedge clk) rst_n = 1;
        cyc(0, 0, 0);
        chk("post_ready", a_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
